initialization_sequencer: RTL

- Clocked controller that turns the decoded write strobes and the latched internal data byte of the 8259A front end into the chip's programming state.
- Sequences ICW1 -> ICW2 -> [ICW3] -> [ICW4] -> ready, and separates A0=1 writes into ICW2/3/4 versus OCW1 by sequence state.
- Holds all configuration, mask and command-mode registers; issues single-cycle EOI/rotate/priority/poll command pulses to the priority and in-service logic.

---
 rtl/initialization_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/initialization_sequencer.sv
// 8259A programming controller: ICW1..ICW4 sequencing, OCW1 mask, OCW2/OCW3 command decode. Optional macro CASCADE_EN enables ICW3/cascade.
// Latency: register updates visible one clock after the strobe; command pulses are high for the single clock after the OCW strobe.
// Backpressure: none; every strobe is accepted on the clock it is sampled, back-to-back strobes included.
module initialization_sequencer #(
    parameter logic [7:0] IMR_RESET_VALUE   = 8'h00,
    parameter logic       READ_SELECT_RESET = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] internal_data_bus,
    input  logic       write_initial_command_word_1,
    input  logic       write_initial_command_word_2_4,
    input  logic       write_operation_control_word_1,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    output logic       init_done,
    output logic       level_or_edge_triggering_config,
    output logic       single_or_cascade_config,
    output logic [4:0] interrupt_vector_base,
    output logic [7:0] cascade_device_config,
    output logic       auto_eoi_config,
    output logic       buffered_master_or_slave_config,
    output logic       buffered_mode_config,
    output logic       special_fully_nest_config,
    output logic [7:0] interrupt_mask,
    output logic       special_mask_mode,
    output logic       read_register_isr_or_irr,
    output logic       priority_rotate_on_aeoi,
    output logic       eoi_pulse,
    output logic       eoi_specific,
    output logic       rotate_pulse,
    output logic       set_priority_pulse,
    output logic [2:0] command_level,
    output logic       poll_command
);

    localparam logic [1:0] CMD_READY = 2'd0;
    localparam logic [1:0] WAIT_ICW2 = 2'd1;
    localparam logic [1:0] WAIT_ICW3 = 2'd2;
    localparam logic [1:0] WAIT_ICW4 = 2'd3;

    logic [1:0] state;
    logic       ic4;
    logic       a0_write;
    logic       ocw_enable;
    logic       seq_single;

    // Both A0=1 strobes describe the same bus event; the sequence state decides its meaning.
    assign a0_write   = write_initial_command_word_2_4 | write_operation_control_word_1;
    assign ocw_enable = init_done && (state == CMD_READY) && !write_initial_command_word_1;

`ifdef CASCADE_EN
    assign seq_single = single_or_cascade_config;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cascade_device_config <= 8'h00;
        end else if (!write_initial_command_word_1 && a0_write && state == WAIT_ICW3) begin
            cascade_device_config <= internal_data_bus;
        end
    end
`else
    // Without cascade support the sequencer always behaves as a single device.
    assign seq_single            = 1'b1;
    assign cascade_device_config = 8'h00;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                           <= CMD_READY;
            init_done                       <= 1'b0;
            ic4                             <= 1'b0;
            level_or_edge_triggering_config <= 1'b0;
            single_or_cascade_config        <= 1'b0;
            interrupt_vector_base           <= 5'h00;
            auto_eoi_config                 <= 1'b0;
            buffered_master_or_slave_config <= 1'b0;
            buffered_mode_config            <= 1'b0;
            special_fully_nest_config       <= 1'b0;
            interrupt_mask                  <= IMR_RESET_VALUE;
        end else if (write_initial_command_word_1) begin
            state                           <= WAIT_ICW2;
            init_done                       <= 1'b0;
            ic4                             <= internal_data_bus[0];
            level_or_edge_triggering_config <= internal_data_bus[3];
            single_or_cascade_config        <= internal_data_bus[1];
            auto_eoi_config                 <= 1'b0;
            buffered_master_or_slave_config <= 1'b0;
            buffered_mode_config            <= 1'b0;
            special_fully_nest_config       <= 1'b0;
            interrupt_mask                  <= IMR_RESET_VALUE;
        end else if (a0_write) begin
            case (state)
                WAIT_ICW2: begin
                    interrupt_vector_base <= internal_data_bus[7:3];
                    if (!seq_single) begin
                        state <= WAIT_ICW3;
                    end else if (ic4) begin
                        state <= WAIT_ICW4;
                    end else begin
                        state     <= CMD_READY;
                        init_done <= 1'b1;
                    end
                end
                WAIT_ICW3: begin
                    if (ic4) begin
                        state <= WAIT_ICW4;
                    end else begin
                        state     <= CMD_READY;
                        init_done <= 1'b1;
                    end
                end
                WAIT_ICW4: begin
                    auto_eoi_config                 <= internal_data_bus[1];
                    buffered_master_or_slave_config <= internal_data_bus[2];
                    buffered_mode_config            <= internal_data_bus[3];
                    special_fully_nest_config       <= internal_data_bus[4];
                    state                           <= CMD_READY;
                    init_done                       <= 1'b1;
                end
                default: begin
                    if (init_done) begin
                        interrupt_mask <= internal_data_bus;
                    end
                end
            endcase
        end
    end

    // OCW2/OCW3 command decode; pulses default low so each lasts exactly one clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eoi_pulse                <= 1'b0;
            eoi_specific             <= 1'b0;
            rotate_pulse             <= 1'b0;
            set_priority_pulse       <= 1'b0;
            command_level            <= 3'd0;
            poll_command             <= 1'b0;
            special_mask_mode        <= 1'b0;
            read_register_isr_or_irr <= READ_SELECT_RESET;
            priority_rotate_on_aeoi  <= 1'b0;
        end else begin
            eoi_pulse          <= 1'b0;
            eoi_specific       <= 1'b0;
            rotate_pulse       <= 1'b0;
            set_priority_pulse <= 1'b0;
            command_level      <= 3'd0;
            poll_command       <= 1'b0;
            if (write_initial_command_word_1) begin
                special_mask_mode        <= 1'b0;
                read_register_isr_or_irr <= 1'b0;
                priority_rotate_on_aeoi  <= 1'b0;
            end else if (ocw_enable) begin
                if (write_operation_control_word_2) begin
                    command_level <= internal_data_bus[2:0];
                    case (internal_data_bus[7:5])
                        3'b001: eoi_pulse <= 1'b1;
                        3'b011: begin
                            eoi_pulse    <= 1'b1;
                            eoi_specific <= 1'b1;
                        end
                        3'b101: begin
                            eoi_pulse    <= 1'b1;
                            rotate_pulse <= 1'b1;
                        end
                        3'b111: begin
                            eoi_pulse    <= 1'b1;
                            rotate_pulse <= 1'b1;
                            eoi_specific <= 1'b1;
                        end
                        3'b110: set_priority_pulse <= 1'b1;
                        3'b100: priority_rotate_on_aeoi <= 1'b1;
                        3'b000: priority_rotate_on_aeoi <= 1'b0;
                        default: ;
                    endcase
                end
                if (write_operation_control_word_3) begin
                    if (internal_data_bus[6]) begin
                        special_mask_mode <= internal_data_bus[5];
                    end
                    if (internal_data_bus[1]) begin
                        read_register_isr_or_irr <= internal_data_bus[0];
                    end
                    poll_command <= internal_data_bus[2];
                end
            end
        end
    end

endmodule
